// File: rtl/alu_op_sweeper.sv
// alu_op_sweeper: steps a combinational ALU through an op range on one operand pair,
// holding each op SETTLE cycles and capturing its result into a per-op buffer.
module alu_op_sweeper #(
    parameter int WIDTH  = 32,
    parameter int OPW    = 5,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [OPW-1:0]   op_first,
    input  logic [OPW-1:0]   op_last,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic             done,
    input  logic [OPW-1:0]   rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);
    localparam int DEPTH = 1 << OPW;

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t             state, state_next;
    logic [7:0]         cnt;
    logic [OPW-1:0]     op_last_q;
    logic [DEPTH-1:0]   valid;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic               accept, cap, last;

    assign accept = start && state != DRIVE;
    assign cap    = state == DRIVE && cnt == 8'(SETTLE - 1);
    assign last   = alu_op == op_last_q;

    always_comb begin
        state_next = state;
        if (accept)
            state_next = DRIVE;
        else if (cap && last)
            state_next = DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            op_last_q <= '0;
            cnt       <= '0;
            valid     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                alu_a     <= a_in;
                alu_b     <= b_in;
                alu_op    <= op_first;
                op_last_q <= op_last;
                cnt       <= '0;
                valid     <= '0;
            end else if (cap) begin
                valid[alu_op] <= 1'b1;
                if (!last) begin
                    alu_op <= alu_op + 1'b1;
                    cnt    <= '0;
                end
            end else if (state == DRIVE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Data storage is never cleared; the valid bits alone decide what is visible.
    always_ff @(posedge clk) begin
        if (cap)
            mem[alu_op] <= alu_out;
    end

    assign busy     = state == DRIVE;
    assign done     = state == DONE;
    assign rd_valid = valid[rd_idx];
    assign rd_data  = rd_valid ? mem[rd_idx] : '0;
endmodule

// File: tb/tb_alu_op_sweeper.sv
// tb_alu_op_sweeper: two sweepers (SETTLE=1 and SETTLE=4) driving an adder-style ALU,
// checked every cycle against a timing model plus hand-computed literals.
module tb_alu_op_sweeper;
    logic        clk = 0;
    logic        rst;
    logic        st [2];
    logic [31:0] a_in, b_in;
    logic [4:0]  op_first, op_last, rd_idx;
    logic [31:0] alu_a [2], alu_b [2], alu_out [2], rd_data [2];
    logic [4:0]  alu_op [2];
    logic        busy [2], done [2], rd_valid [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_op_sweeper #(.WIDTH(32), .OPW(5), .SETTLE(1)) u0 (
        .clk(clk), .rst(rst), .start(st[0]), .a_in(a_in), .b_in(b_in),
        .op_first(op_first), .op_last(op_last), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
        .alu_op(alu_op[0]), .alu_out(alu_out[0]), .busy(busy[0]), .done(done[0]),
        .rd_idx(rd_idx), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]));

    alu_op_sweeper #(.WIDTH(32), .OPW(5), .SETTLE(4)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .a_in(a_in), .b_in(b_in),
        .op_first(op_first), .op_last(op_last), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
        .alu_op(alu_op[1]), .alu_out(alu_out[1]), .busy(busy[1]), .done(done[1]),
        .rd_idx(rd_idx), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]));

    assign alu_out[0] = alu_a[0] + alu_b[0] + 32'(alu_op[0]);
    assign alu_out[1] = alu_a[1] + alu_b[1] + 32'(alu_op[1]);

    task automatic chk(input int i, input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL u%0d %s: got %0d expected %0d at %0t", i, nm, got, exp, $time);
        end
    endtask

    function automatic int settle_of(input int i);
        return i == 0 ? 1 : 4;
    endfunction

    // Model: elapsed cycles t since start; op k occupies t in [k*S,(k+1)*S).
    bit          m_act [2], m_done [2];
    int          m_t [2], m_n [2], m_first [2], eop [2];
    logic [31:0] ea [2], eb [2];
    logic [31:0] m_val [2];
    logic [31:0] m_mem [2][32];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 0; m_done[i] = 0; ea[i] = 0; eb[i] = 0; eop[i] = 0; m_val[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int s;
                s = settle_of(i);
                if (st[i] && !m_act[i]) begin
                    ea[i] = a_in; eb[i] = b_in; m_first[i] = int'(op_first);
                    m_n[i] = ((int'(op_last) - int'(op_first)) & 31) + 1;
                    m_t[i] = 0; m_act[i] = 1; m_done[i] = 0; m_val[i] = 0; eop[i] = int'(op_first);
                end else if (m_act[i]) begin
                    if ((m_t[i] + 1) % s == 0) begin
                        int op;
                        op = (m_first[i] + m_t[i] / s) % 32;
                        m_mem[i][op] = ea[i] + eb[i] + 32'(op);
                        m_val[i][op] = 1'b1;
                    end
                    m_t[i]++;
                    if (m_t[i] == m_n[i] * s) begin
                        m_act[i] = 0; m_done[i] = 1;
                    end else
                        eop[i] = (m_first[i] + m_t[i] / s) % 32;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk(i, "alu_a", alu_a[i], ea[i]);
            chk(i, "alu_b", alu_b[i], eb[i]);
            chk(i, "alu_op", alu_op[i], eop[i]);
            chk(i, "busy", busy[i], m_act[i]);
            chk(i, "done", done[i], m_done[i]);
            chk(i, "rd_valid", rd_valid[i], m_val[i][rd_idx]);
            chk(i, "rd_data", rd_data[i], m_val[i][rd_idx] ? m_mem[i][rd_idx] : 32'd0);
        end
    end

    logic [4:0] seq [$];

    task automatic run(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] f, input logic [4:0] l, input int poke, output int nb);
        @(negedge clk);
        a_in = a; b_in = b; op_first = f; op_last = l; st[i] = 1;
        @(negedge clk);
        st[i] = 0; nb = 0; seq.delete();
        for (int c = 0; c < 200; c++) begin
            if (done[i]) break;
            if (busy[i]) begin
                nb++;
                seq.push_back(alu_op[i]);
            end
            st[i] = (c == poke);
            if (c == poke) a_in = 99;
            @(negedge clk);
        end
        st[i] = 0;
        chk(i, "done_after_sweep", done[i], 1);
    endtask

    task automatic rd(input int i, input logic [4:0] idx, input logic [31:0] d, input logic v);
        rd_idx = idx;
        #1;
        chk(i, "rd_data_lit", rd_data[i], d);
        chk(i, "rd_valid_lit", rd_valid[i], v);
    endtask

    task automatic chk_seq(input int i, input int n, input int e [8]);
        chk(i, "seq_len", seq.size(), n);
        for (int k = 0; k < n && k < seq.size(); k++)
            chk(i, "seq_op", seq[k], e[k]);
    endtask

    task automatic basic_reads();
        for (int k = 0; k < 7; k++)
            rd(0, 5'(k), 32'(7 + k), 1);
        rd(0, 7, 0, 0);
    endtask

    initial begin
        int nb;
        rst = 1; st[0] = 0; st[1] = 0;
        a_in = 0; b_in = 0; op_first = 0; op_last = 0; rd_idx = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk(i, "rst_busy", busy[i], 0);
            chk(i, "rst_done", done[i], 0);
            chk(i, "rst_op", alu_op[i], 0);
            chk(i, "rst_valid", rd_valid[i], 0);
        end
        rst = 0;

        run(0, 5, 2, 0, 6, -1, nb);
        chk(0, "basic_busy_cycles", nb, 7);
        chk_seq(0, 7, '{0, 1, 2, 3, 4, 5, 6, 0});
        basic_reads();

        run(1, 3, 4, 3, 4, -1, nb);
        chk(1, "settle_busy_cycles", nb, 8);
        chk_seq(1, 8, '{3, 3, 3, 3, 4, 4, 4, 4});
        rd(1, 3, 10, 1);
        rd(1, 4, 11, 1);

        run(0, 1, 1, 30, 1, -1, nb);
        chk(0, "wrap_busy_cycles", nb, 4);
        chk_seq(0, 4, '{30, 31, 0, 1, 0, 0, 0, 0});
        rd(0, 30, 32, 1);
        rd(0, 31, 33, 1);
        rd(0, 0, 2, 1);
        rd(0, 1, 3, 1);
        for (int k = 2; k < 30; k++)
            rd(0, 5'(k), 0, 0);

        run(0, 5, 2, 0, 6, 3, nb);
        chk(0, "poke_busy_cycles", nb, 7);
        basic_reads();
        run(0, 0, 0, 5, 5, -1, nb);
        chk(0, "single_busy_cycles", nb, 1);
        for (int k = 0; k < 8; k++)
            rd(0, 5'(k), k == 5 ? 32'd5 : 32'd0, k == 5);

        @(negedge clk);
        a_in = 5; b_in = 2; op_first = 0; op_last = 6; st[0] = 1;
        @(negedge clk);
        st[0] = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1;
        #1;
        chk(0, "arst_alu_a", alu_a[0], 0);
        chk(0, "arst_alu_b", alu_b[0], 0);
        chk(0, "arst_alu_op", alu_op[0], 0);
        chk(0, "arst_busy", busy[0], 0);
        chk(0, "arst_done", done[0], 0);
        for (int k = 0; k < 32; k++)
            rd(0, 5'(k), 0, 0);
        @(negedge clk);
        rst = 0;
        run(0, 5, 2, 0, 6, -1, nb);
        chk(0, "post_rst_busy_cycles", nb, 7);
        basic_reads();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_op_sweeper.md
# alu_op_sweeper

Sequential stimulus engine for the combinational ALU `top`, which takes `a`, `b` and `op` and returns `out`. It sits on the driving side of that interface. It latches one operand pair and an op range, presents each op to the ALU in turn, and holds each op for a fixed settle time. After the settle time it captures `out` into a 32-entry result buffer indexed by op code. It replaces hand-timed op stepping in benches and on-board demos with a cycle-exact, readable sweep.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width.
- `OPW`, 5, op code width; buffer depth is 2^OPW.
- `SETTLE`, 1, cycles each op is held before capture; legal range 1..255.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  sweep request, sampled on rising edge.
- `a_in`, `b_in`  in  WIDTH  operands, latched on accepted start.
- `op_first`, `op_last`  in  OPW  inclusive op range, latched on accepted start.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to ALU `a`/`b`.
- `alu_op`  out  OPW  registered op to ALU `op`.
- `alu_out`  in  WIDTH  ALU result.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep finished; held until next accepted start.
- `rd_idx`  in  OPW  result buffer read index.
- `rd_data`  out  WIDTH  combinational read of entry `rd_idx`; 0 if the entry is not valid.
- `rd_valid`  out  1  entry `rd_idx` was written in the current/last sweep.

## Operation
- The FSM has three states: IDLE, DRIVE and DONE. Reset enters IDLE.
- **start accepted in IDLE or DONE:**
  - Latch `a_in`, `b_in`, `op_first` and `op_last`.
  - Clear all 32 valid bits.
  - Load `alu_op`=`op_first` and the settle counter `cnt`=0.
  - Enter DRIVE; `busy`=1 and `done`=0.
- **start in DRIVE** is ignored, with no effect on the sweep.
- **DRIVE, each edge:**
  - If `cnt`==`SETTLE`-1:
    - Write `alu_out` to `mem[alu_op]` and set `valid[alu_op]`.
    - If `alu_op`==`op_last`, enter DONE. Otherwise increment `alu_op` modulo 2^OPW and set `cnt`=0.
  - Otherwise increment `cnt`.
- **Range wrap:** the op range wraps modulo 32.
  - `op_first`=30, `op_last`=1 sweeps 30, 31, 0, 1.
  - `op_first`==`op_last` sweeps one op.
  - Number of ops N = ((`op_last` − `op_first`) mod 32) + 1.
- **Outputs in IDLE/DONE:** `alu_a`, `alu_b` and `alu_op` hold their last driven values.
- **Buffer contents:** the buffer is not cleared, only invalidated. `rd_data` masks stale entries to 0.
- **Reset values (asynchronous):**
  - `alu_a`=0, `alu_b`=0, `alu_op`=0.
  - `busy`=0, `done`=0, `cnt`=0.
  - All valid bits 0, so `rd_data`=0 and `rd_valid`=0.
  - Reset mid-sweep aborts immediately and discards partial results.

## Timing
- Edge E0 samples `start`=1.
- After E0: `alu_a`/`alu_b`/`alu_op` reflect the new values and `busy`=1.
- Op k (k=0..N−1) is presented from E0+k·S to E0+(k+1)·S, where S=`SETTLE`. Its capture happens at edge E0+(k+1)·S, using `alu_out` as sampled at that edge.
- `busy` is high for exactly N·S cycles.
- `done` rises after edge E0+N·S, in the same cycle that `busy` falls.
- Start-to-done latency is N·S cycles. The full 32-op sweep at S=1 takes 32 cycles.
- A start at the DONE edge restarts immediately, with no dead cycle. `done` drops after that edge.
- Buffer read is combinational from `rd_idx`. A capture at edge E is visible on `rd_data` after E.
- `start` and `rst` together: `rst` wins.

## Test plan
The bench model for the ALU is `alu_out` = `alu_a` + `alu_b` + `alu_op`, combinational.
- **Basic sweep:** `a_in`=5, `b_in`=2, ops 0..6, S=1, start pulse.
  - `busy` is high 7 cycles, then `done`=1.
  - `rd_data` at idx 0..6 = 7..13 with `rd_valid`=1.
  - idx 7 reads 0 with `rd_valid`=0.
- **Settle hold:** S=4, ops 3..4.
  - `alu_op` holds 3 for 4 cycles, then 4 for 4 cycles.
  - `busy` is high 8 cycles.
  - Reads give idx3=10 and idx4=11.
- **Wrap:** ops 30..1, a=1, b=1.
  - `alu_op` sequence is 30, 31, 0, 1.
  - Reads give idx30=32, idx31=33, idx0=2, idx1=3; every other index is invalid.
- **Busy/restart:** a start pulse mid-sweep is ignored, and the result matches an undisturbed run. A new start (a=0, b=0, ops 5..5) from DONE clears the prior valid bits: only idx5=5 is valid.
- **Reset mid-operation:** assert `rst` at cycle 3 of a 7-op sweep.
  - All outputs are 0 immediately (asynchronous), with `busy`=0 and `done`=0.
  - `rd_valid`=0 for all indexes.
  - A subsequent start completes normally.
